// File: rtl/axis_header_insert.sv
// axis_header_insert
//   Prepends a per-packet header beat (side channel) to an AXI-Stream packet.
//   The output is byte-packed MSB-first; when the header pushes bytes past
//   the final data beat, one extra trailing beat is emitted from FLUSH.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   valid_in/data_in/keep_in/last_in  data stream in (MSB-aligned keep)
//   ready_in                          data stream ready
//   valid_insert/data_insert          header beat, valid bytes LSB-aligned
//   keep_insert/byte_insert_cnt       header byte enables / byte count H
//   ready_insert                      header ready (IDLE only)
//   valid_out/data_out/keep_out       registered output stream
//   last_out/ready_out
//   hdr_err                           sticky header-format error (only with
//                                     HDR_KEEP_CHECK_EN defined)
//
// Build option: define HDR_KEEP_CHECK_EN to check keep_insert against
// byte_insert_cnt and to clamp the header byte count to the beat width.
//
// state  | meaning
// IDLE   | waiting for a header beat; residual holds nothing
// STREAM | merging residual header/data bytes with each incoming data beat
// FLUSH  | last data beat overflowed; emit the leftover bytes as final beat

module axis_header_insert #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
`ifdef HDR_KEEP_CHECK_EN
  output logic                    hdr_err,
`endif
  input  logic                    ready_out
);

  localparam int CW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WD-1:0]      res_data;
  logic [CW-1:0]           hcnt;
  logic [CW-1:0]           flush_cnt;
  logic [CW-1:0]           h_in;

  logic                    adv, hdr_fire, beat_fire, fit;
  int                      h, k, flush_n;
  logic [2*DATA_WD-1:0]    joined;
  logic [DATA_BYTE_WD-1:0] beat_keep, flush_keep;
  logic [DATA_WD-1:0]      beat_data, flush_data, res_next;

  function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input int n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < n) m[DATA_BYTE_WD-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] lsb_mask(input int n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [DATA_BYTE_WD-1:0] m);
    logic [DATA_WD-1:0] e;
    e = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      e[8*i +: 8] = {8{m[i]}};
    return e;
  endfunction

  function automatic int popcount(input logic [DATA_BYTE_WD-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (v[i]) c++;
    return c;
  endfunction

  assign adv       = !valid_out || ready_out;
  assign hdr_fire  = valid_insert && ready_insert;
  assign beat_fire = valid_in && ready_in;

`ifdef HDR_KEEP_CHECK_EN
  logic hdr_bad;

  always_comb begin
    if (int'(byte_insert_cnt) > DATA_BYTE_WD) h_in = CW'(DATA_BYTE_WD);
    else                                      h_in = byte_insert_cnt;
    hdr_bad = (popcount(keep_insert) != int'(byte_insert_cnt)) ||
              (byte_insert_cnt == '0) ||
              (int'(byte_insert_cnt) > DATA_BYTE_WD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    hdr_err <= 1'b0;
    else if (hdr_fire && hdr_bad)  hdr_err <= 1'b1;
  end
`else
  logic unused_keep_insert;

  assign unused_keep_insert = ^keep_insert;
  assign h_in               = byte_insert_cnt;
`endif

  // Byte-merge datapath. The residual is kept LSB-aligned, so shifting the
  // concatenation {residual, data} right by H bytes leaves the next output
  // beat in the low word.
  always_comb begin
    h          = int'(hcnt);
    k          = popcount(keep_in);
    fit        = (k <= DATA_BYTE_WD - h);
    flush_n    = k - (DATA_BYTE_WD - h);
    joined     = {res_data, data_in} >> (8 * h);
    beat_keep  = (last_in && fit) ? msb_mask(h + k) : '1;
    beat_data  = joined[DATA_WD-1:0] & expand(beat_keep);
    flush_keep = msb_mask(int'(flush_cnt));
    flush_data = (res_data << (8 * (DATA_BYTE_WD - h))) & expand(flush_keep);
    res_next   = data_in & expand(lsb_mask(h));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hdr_fire) state_nxt = STREAM;
      STREAM:  if (beat_fire && last_in) state_nxt = fit ? IDLE : FLUSH;
      FLUSH:   if (adv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready_insert is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    ready_insert = 1'b0;
    ready_in     = 1'b0;
    case (state)
      IDLE:    ready_insert = rst_n;
      STREAM:  ready_in     = adv;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      hcnt      <= '0;
      flush_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (hdr_fire) begin
        hcnt     <= h_in;
        res_data <= data_insert & expand(lsb_mask(int'(h_in)));
      end
      if (adv) begin
        if (beat_fire) begin
          valid_out <= 1'b1;
          data_out  <= beat_data;
          keep_out  <= beat_keep;
          last_out  <= last_in && fit;
          res_data  <= res_next;
          if (last_in && !fit) flush_cnt <= CW'(flush_n);
        end else if (state == FLUSH) begin
          valid_out <= 1'b1;
          data_out  <= flush_data;
          keep_out  <= flush_keep;
          last_out  <= 1'b1;
        end else begin
          valid_out <= 1'b0;
          data_out  <= '0;
          keep_out  <= '0;
          last_out  <= 1'b0;
        end
      end
    end
  end

endmodule
